serial_subtractor: RTL and testbench

Bit-serial N-bit subtractor built around a one-bit full-subtractor cell, the borrow-chain counterpart of the team's full-adder datapath. It latches a minuend, a subtractor operand and a borrow-in on a start request. It then resolves one bit per clock, LSB first, through a registered borrow. It presents the difference and final borrow with a one-cycle done pulse. It sits between operand registers and any consumer that can tolerate WIDTH+1 cycles of latency in exchange for a single-bit datapath.

---
 rtl/serial_arith_pkg.sv | 15 +
 rtl/full_subtractor.sv | 14 +
 rtl/serial_subtractor.sv | 111 +++++++++++
 tb/tb_serial_subtractor.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/serial_arith_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks: FSM states and
// the helper that sizes the bit counter from the operand width.
package serial_arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int cntWidth(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/full_subtractor.sv
// One-bit full-subtractor cell: computes x - y - bin and the borrow that
// ripples into the next more-significant bit.
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = x ^ y ^ bin;
  assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor: latches operands on start, resolves one
// bit per clock LSB first through a registered borrow, then pulses done.
module serial_subtractor
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             b_out
);

  localparam int CW = cntWidth(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             br_q, br_d;
  logic             bout_q, bout_d;
  logic             cellD, cellBout;

  full_subtractor u_cell (
    .x    (sa_q[0]),
    .y    (sb_q[0]),
    .bin  (br_q),
    .d    (cellD),
    .bout (cellBout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      res_q   <= '0;
      diff_q  <= '0;
      cnt_q   <= '0;
      br_q    <= 1'b0;
      bout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      res_q   <= res_d;
      diff_q  <= diff_d;
      cnt_q   <= cnt_d;
      br_q    <= br_d;
      bout_q  <= bout_d;
    end
  end

  // The result fills from the MSB side so the first (LSB) bit ends at bit 0.
  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    res_d   = res_q;
    diff_d  = diff_q;
    cnt_d   = cnt_q;
    br_d    = br_q;
    bout_d  = bout_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          sa_d    = a;
          sb_d    = b;
          br_d    = b_in;
          res_d   = '0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sa_d  = sa_q >> 1;
        sb_d  = sb_q >> 1;
        br_d  = cellBout;
        res_d = {cellD, res_q[WIDTH-1:1]};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = DONE;
          diff_d  = res_d;
          bout_d  = cellBout;
          cnt_d   = '0;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy  = (state_q == RUN);
  assign done  = (state_q == DONE);
  assign diff  = diff_q;
  assign b_out = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed vector table, random
// operations against an arithmetic model, and multi-cycle corner sequences.
module tb_serial_subtractor;

  localparam int WIDTH = 8;

  typedef struct {
    logic [7:0] va;
    logic [7:0] vb;
    logic       vbin;
    logic [7:0] expDiff;
    logic       expBout;
  } vec_t;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       b_in;
  logic       busy;
  logic       done;
  logic [7:0] diff;
  logic       b_out;

  int total;
  int bad;

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .b_in  (b_in),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .b_out (b_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // Reference: borrow-out is bit WIDTH of the widened unsigned difference.
  function automatic logic [8:0] refSub(input logic [7:0] x, input logic [7:0] y, input logic bi);
    return {1'b0, x} - {1'b0, y} - {8'd0, bi};
  endfunction

  // Drives one request and returns its result, latency in edges after the
  // start edge, and busy-cycle count.
  task automatic applyStimulus(input logic [7:0] ta, input logic [7:0] tb, input logic tbin,
                               output logic [7:0] od, output logic ob,
                               output int lat, output int busyCnt);
    @(negedge clk);
    a = ta; b = tb; b_in = tbin; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    busyCnt = 0;
    while (!done && lat < 50) begin
      if (busy) busyCnt++;
      @(negedge clk);
      lat++;
    end
    checkOutput("busy_with_done", {31'd0, busy}, 32'd0);
    od = diff;
    ob = b_out;
  endtask

  initial begin
    vec_t       vecs[4];
    logic [7:0] gd;
    logic       gb;
    int         lat;
    int         bcnt;
    int         pulses;
    logic [8:0] r;
    logic [8:0] expQ[$];
    int         lastDone;
    int         cyc;
    int         seen;

    total = 0;
    bad   = 0;
    rst = 1'b1; start = 1'b0; a = '0; b = '0; b_in = 1'b0;

    vecs[0] = '{8'h5A, 8'h23, 1'b0, 8'h37, 1'b0};
    vecs[1] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1};
    vecs[2] = '{8'h10, 8'h0F, 1'b1, 8'h00, 1'b0};
    vecs[3] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};

    repeat (2) @(negedge clk);
    checkOutput("reset_busy", {31'd0, busy}, 32'd0);
    checkOutput("reset_done", {31'd0, done}, 32'd0);
    checkOutput("reset_diff", {24'd0, diff}, 32'd0);
    checkOutput("reset_bout", {31'd0, b_out}, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 4; i++) begin
      applyStimulus(vecs[i].va, vecs[i].vb, vecs[i].vbin, gd, gb, lat, bcnt);
      checkOutput($sformatf("vec%0d_latency", i), lat, WIDTH);
      checkOutput($sformatf("vec%0d_busy", i), bcnt, WIDTH);
      checkOutput($sformatf("vec%0d_diff", i), {24'd0, gd}, {24'd0, vecs[i].expDiff});
      checkOutput($sformatf("vec%0d_bout", i), {31'd0, gb}, {31'd0, vecs[i].expBout});
      @(negedge clk);
      checkOutput($sformatf("vec%0d_done_single", i), {31'd0, done}, 32'd0);
    end

    for (int i = 0; i < 20; i++) begin
      logic [7:0] ra, rb;
      logic       rbi;
      ra  = 8'($urandom);
      rb  = 8'($urandom);
      rbi = 1'($urandom);
      r   = refSub(ra, rb, rbi);
      applyStimulus(ra, rb, rbi, gd, gb, lat, bcnt);
      checkOutput($sformatf("rand%0d_latency", i), lat, WIDTH);
      checkOutput($sformatf("rand%0d_diff", i), {24'd0, gd}, {24'd0, r[7:0]});
      checkOutput($sformatf("rand%0d_bout", i), {31'd0, gb}, {31'd0, r[8]});
    end

    // Start re-asserted with other operands during RUN and DONE is ignored.
    @(negedge clk);
    a = 8'h80; b = 8'h01; b_in = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    a = 8'h00; b = 8'h00;
    pulses = 0;
    lat = 0;
    while (!done && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    if (done) pulses++;
    checkOutput("ignore_latency", lat, WIDTH);
    checkOutput("ignore_diff", {24'd0, diff}, 32'h7F);
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (done) pulses++;
      checkOutput($sformatf("ignore_hold%0d", i), {24'd0, diff}, 32'h7F);
      checkOutput($sformatf("ignore_idle%0d", i), {31'd0, busy}, 32'd0);
      @(negedge clk);
    end
    checkOutput("ignore_pulses", pulses, 1);

    // Asynchronous reset three cycles into RUN aborts the operation.
    a = 8'h33; b = 8'h11; b_in = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("abort_busy", {31'd0, busy}, 32'd0);
    checkOutput("abort_done", {31'd0, done}, 32'd0);
    checkOutput("abort_diff", {24'd0, diff}, 32'd0);
    checkOutput("abort_bout", {31'd0, b_out}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done || busy) pulses++;
    end
    checkOutput("abort_no_activity", pulses, 0);
    applyStimulus(8'h05, 8'h03, 1'b0, gd, gb, lat, bcnt);
    checkOutput("after_abort_diff", {24'd0, gd}, 32'h02);
    checkOutput("after_abort_bout", {31'd0, gb}, 32'd0);

    // Start held high: three back-to-back operations, ten cycles apart.
    @(negedge clk);
    a = 8'($urandom); b = 8'($urandom); b_in = 1'($urandom);
    expQ.push_back(refSub(a, b, b_in));
    start = 1'b1;
    seen = 0;
    lastDone = -1;
    cyc = 0;
    while (seen < 3 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (done) begin
        r = expQ.pop_front();
        checkOutput($sformatf("b2b%0d_diff", seen), {24'd0, diff}, {24'd0, r[7:0]});
        checkOutput($sformatf("b2b%0d_bout", seen), {31'd0, b_out}, {31'd0, r[8]});
        if (lastDone >= 0)
          checkOutput($sformatf("b2b%0d_spacing", seen), cyc - lastDone, WIDTH + 2);
        lastDone = cyc;
        seen++;
        if (seen < 3) begin
          a = 8'($urandom); b = 8'($urandom); b_in = 1'($urandom);
          expQ.push_back(refSub(a, b, b_in));
        end else begin
          start = 1'b0;
        end
      end
    end
    start = 1'b0;
    checkOutput("b2b_count", seen, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
